// File: rtl/vga_pkg.sv
// Default VGA timing (640x480@60) and the total-length helper.
// Shared by the timing generator and the pixel generators.
package vga_pkg;

    localparam int VGA_HD = 640;
    localparam int VGA_HF = 16;
    localparam int VGA_HR = 96;
    localparam int VGA_HB = 48;
    localparam int VGA_VD = 480;
    localparam int VGA_VF = 10;
    localparam int VGA_VR = 2;
    localparam int VGA_VB = 33;

    function automatic int totalLen(input int disp, input int front, input int sync, input int back);
        return disp + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_delay.sv
// Shift register of configurable width and depth. It advances only when ce is high.
// On reset, every stage loads RST_VAL. With depth 0 the module is a plain wire.
module vga_delay #(
    parameter int            W       = 1,
    parameter int            DEPTH   = 0,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clkP,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        assign q = d;
    end else begin : g_pipe
        logic [W-1:0] stage [DEPTH];

        // NOTE: every stage is cleared on reset, not just the head. Each stage holds
        // a visible output value, so stale sync or strobe bits must not survive reset.
        always_ff @(posedge clkP or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else if (ce) begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator. It produces sync pulses, the video flag,
// pixel coordinates and start strobes, with an optional output delay.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int HD   = VGA_HD,
    parameter int HF   = VGA_HF,
    parameter int HR   = VGA_HR,
    parameter int HB   = VGA_HB,
    parameter int VD   = VGA_VD,
    parameter int VF   = VGA_VF,
    parameter int VR   = VGA_VR,
    parameter int VB   = VGA_VB,
    parameter bit HPOL = 1'b0,
    parameter bit VPOL = 1'b0,
    parameter int XW   = 11,
    parameter int YW   = 10,
    parameter int PIPE = 0
) (
    input  logic          clkP,
    input  logic          rst,
    input  logic          ce,
    output logic          sincH,
    output logic          sincV,
    output logic          video,
    output logic [XW-1:0] pixelX,
    output logic [YW-1:0] pixelY,
    output logic          inicioLinea,
    output logic          inicioFrame
);

    localparam int HT = totalLen(HD, HF, HR, HB);
    localparam int VT = totalLen(VD, VF, VR, VB);
    localparam int BW = XW + YW + 5;

    if (HD <= 0 || HR <= 0 || VD <= 0 || VR <= 0 || HF < 0 || HB < 0 || VF < 0 || VB < 0) begin : g_badSizes
        $error("vga_timing_gen: active and sync widths must be positive, porches non-negative");
    end
    if (XW < 1 || XW > 30 || (2 ** XW) < HT || YW < 1 || YW > 30 || (2 ** YW) < VT) begin : g_badWidths
        $error("vga_timing_gen: XW/YW too small for the line/frame totals");
    end
    if (PIPE < 0 || PIPE > 7) begin : g_badPipe
        $error("vga_timing_gen: PIPE must be 0..7");
    end

    localparam logic [XW-1:0] H_LAST   = XW'(HT - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(HD);
    localparam logic [XW-1:0] H_SYNC_B = XW'(HD + HF);
    localparam logic [XW-1:0] H_SYNC_E = XW'(HD + HF + HR - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(VT - 1);
    localparam logic [YW-1:0] V_ACT    = YW'(VD);
    localparam logic [YW-1:0] V_SYNC_B = YW'(VD + VF);
    localparam logic [YW-1:0] V_SYNC_E = YW'(VD + VF + VR - 1);
    localparam logic [BW-1:0] RST_BUS  = {~HPOL, ~VPOL, {(BW - 2){1'b0}}};

    logic [XW-1:0] hCnt;
    logic [YW-1:0] vCnt;
    logic          hs;
    logic          vs;
    logic          active;
    logic [BW-1:0] busIn;
    logic [BW-1:0] busOut;

    // NOTE: sequential state uses non-blocking assignments. Every register then
    // samples the old counter values on the same edge.
    always_ff @(posedge clkP or posedge rst) begin
        if (rst) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (ce) begin
            if (hCnt == H_LAST) begin
                hCnt <= '0;
                vCnt <= (vCnt == V_LAST) ? '0 : vCnt + YW'(1);
            end else begin
                hCnt <= hCnt + XW'(1);
            end
        end
    end

    // NOTE: each combinational output gets its value on every path, so no latches are inferred.
    always_comb begin
        active = (hCnt < H_ACT) && (vCnt < V_ACT);
        hs     = (hCnt >= H_SYNC_B) && (hCnt <= H_SYNC_E);
        vs     = (vCnt >= V_SYNC_B) && (vCnt <= V_SYNC_E);
        busIn  = {hs ? HPOL : ~HPOL,
                  vs ? VPOL : ~VPOL,
                  active,
                  hCnt,
                  vCnt,
                  hCnt == '0,
                  (hCnt == '0) && (vCnt == '0)};
    end

    // Stage 0 and the PIPE extra stages form one delay line.
    // All outputs therefore share the same latency.
    vga_delay #(
        .W       (BW),
        .DEPTH   (PIPE + 1),
        .RST_VAL (RST_BUS)
    ) uDelay (
        .clkP (clkP),
        .rst  (rst),
        .ce   (ce),
        .d    (busIn),
        .q    (busOut)
    );

    assign {sincH, sincV, video, pixelX, pixelY, inicioLinea, inicioFrame} = busOut;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with three instances: defaults, PIPE=3/HPOL=1,
// and a small 15x11 mode that runs many whole frames quickly.
module tb_vga_timing_gen;

    logic clkP = 1'b0;
    logic rst  = 1'b1;
    logic ce   = 1'b0;

    always #5 clkP = ~clkP;

    logic        dSh, dSv, dVid, dIl, dIf;
    logic [10:0] dX;
    logic [9:0]  dY;
    logic        pSh, pSv, pVid, pIl, pIf;
    logic [10:0] pX;
    logic [9:0]  pY;
    logic        sSh, sSv, sVid, sIl, sIf;
    logic [3:0]  sX;
    logic [3:0]  sY;

    vga_timing_gen uDef (
        .clkP(clkP), .rst(rst), .ce(ce),
        .sincH(dSh), .sincV(dSv), .video(dVid), .pixelX(dX), .pixelY(dY),
        .inicioLinea(dIl), .inicioFrame(dIf)
    );

    vga_timing_gen #(.PIPE(3), .HPOL(1'b1)) uPip (
        .clkP(clkP), .rst(rst), .ce(ce),
        .sincH(pSh), .sincV(pSv), .video(pVid), .pixelX(pX), .pixelY(pY),
        .inicioLinea(pIl), .inicioFrame(pIf)
    );

    vga_timing_gen #(
        .HD(8), .HF(2), .HR(3), .HB(2), .VD(6), .VF(2), .VR(2), .VB(1), .XW(4), .YW(4)
    ) uSm (
        .clkP(clkP), .rst(rst), .ce(ce),
        .sincH(sSh), .sincV(sSv), .video(sVid), .pixelX(sX), .pixelY(sY),
        .inicioLinea(sIl), .inicioFrame(sIf)
    );

    // Layout: [25]sincH [24]sincV [23]video [22]inicioLinea [21]inicioFrame [20:11]y [10:0]x
    logic [31:0] obsDef, obsPip, obsSm;
    assign obsDef = {6'b0, dSh, dSv, dVid, dIl, dIf, dY, dX};
    assign obsPip = {6'b0, pSh, pSv, pVid, pIl, pIf, pY, pX};
    assign obsSm  = {6'b0, sSh, sSv, sVid, sIl, sIf, 6'b0, sY, 7'b0, sX};

    int total = 0;
    int bad   = 0;
    int t     = 0;
    int cyc   = 0;
    int phase = 0;
    int defLow = 0, defFirst = -1, defLast = -1, defVid = 0, pipHigh = 0;
    int lastLineCyc = -1, linePeriods = 0;
    int lastFrameT = -1, smFrames = 0, smLines = 0, smVsLow = 0;
    logic [31:0] prevSm = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    // Expected outputs after ce-tick t (t=0: still in reset) for delay p.
    function automatic logic [31:0] model(input int tt, input int p,
                                          input int hd, input int hf, input int hr, input int hb,
                                          input int vd, input int vf, input int vr, input int vb,
                                          input bit hpol, input bit vpol);
        int ht, vt, n, h, v;
        logic sh, sv, vid, il, fr;
        ht = hd + hf + hr + hb;
        vt = vd + vf + vr + vb;
        if (tt <= p) return {6'b0, ~hpol, ~vpol, 24'b0};
        n   = tt - 1 - p;
        h   = n % ht;
        v   = (n / ht) % vt;
        vid = (h < hd) && (v < vd);
        sh  = (h >= hd + hf && h < hd + hf + hr) ? hpol : ~hpol;
        sv  = (v >= vd + vf && v < vd + vf + vr) ? vpol : ~vpol;
        il  = (h == 0);
        fr  = (h == 0) && (v == 0);
        return {6'b0, sh, sv, vid, il, fr, 10'(v), 11'(h)};
    endfunction

    task automatic account();
        if (phase == 1 && t <= 800) begin
            if (!dSh) begin
                defLow++;
                if (defFirst < 0) defFirst = int'(dX);
                defLast = int'(dX);
            end
            if (dVid) defVid++;
        end
        if (phase == 1 && t >= 4 && t <= 803 && pSh) pipHigh++;
        if (dIl) begin
            if (lastLineCyc >= 0) begin
                check("line_period_clk", cyc - lastLineCyc, (phase == 2) ? 1600 : 800);
                linePeriods++;
            end
            lastLineCyc = cyc;
        end
        if (sIf) begin
            if (lastFrameT >= 0) begin
                check("sm_frame_period", t - lastFrameT, 165);
                check("sm_lines_per_frame", smLines, 11);
                check("sm_vsync_low_ticks", smVsLow, 30);
                check("sm_wrap_prev_xy", {11'b0, prevSm[20:0]}, {11'b0, 10'd10, 11'd14});
            end
            smFrames++;
            lastFrameT = t;
            smLines    = 0;
            smVsLow    = 0;
        end
        if (sIl) smLines++;
        if (!sSv) smVsLow++;
        prevSm = obsSm;
    endtask

    task automatic cycle(input logic ceVal);
        logic ticked;
        ce = ceVal;
        @(posedge clkP);
        cyc++;
        ticked = ceVal && !rst;
        if (ticked) t++;
        #1;
        check("def", obsDef, model(t, 0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
        check("pip", obsPip, model(t, 3, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b0));
        check("sm",  obsSm,  model(t, 0, 8, 2, 3, 2, 6, 2, 2, 1, 1'b0, 1'b0));
        if (ticked) account();
    endtask

    initial begin
        // Reset held for 3 cycles with ce high
        for (int i = 0; i < 3; i++) cycle(1'b1);
        check("rst_def", obsDef, 32'h0300_0000);
        check("rst_pip", obsPip, 32'h0100_0000);
        check("rst_sm",  obsSm,  32'h0300_0000);
        @(negedge clkP);
        rst   = 1'b0;
        phase = 1;

        // Full-rate run: line 0 of the default mode, several small frames
        cycle(1'b1);
        check("first_out", obsDef, 32'h03E0_0000);
        for (int i = 1; i < 1000; i++) cycle(1'b1);
        check("def_hsync_low_count", defLow, 96);
        check("def_hsync_first_x", defFirst, 656);
        check("def_hsync_last_x", defLast, 751);
        check("def_video_count", defVid, 640);
        check("pip_hsync_high_count", pipHigh, 96);

        // ce pulsed 1-in-2: outputs hold on idle cycles, line takes 1600 clocks
        phase       = 2;
        lastLineCyc = -1;
        for (int i = 0; i < 1500; i++) begin
            cycle(1'b1);
            cycle(1'b0);
        end
        check("line_checks_seen", linePeriods, 2);
        check("sm_frames_seen", smFrames, 16);

        // Asynchronous reset mid-frame, between clock edges
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_def", obsDef, 32'h0300_0000);
        check("async_rst_pip", obsPip, 32'h0100_0000);
        check("async_rst_sm",  obsSm,  32'h0300_0000);
        phase       = 3;
        t           = 0;
        lastLineCyc = -1;
        lastFrameT  = -1;
        for (int i = 0; i < 3; i++) cycle(1'b1);
        @(negedge clkP);
        rst = 1'b0;
        cycle(1'b1);
        check("restart_first_out", obsDef, 32'h03E0_0000);
        for (int i = 1; i < 200; i++) cycle(1'b1);
        check("sm_frames_after_rst", smFrames, 18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator for the video output path. Horizontal and vertical counters run at the pixel rate set by a clock enable and produce sincH/sincV with selectable polarity, a video-active flag, pixel coordinates, and line/frame start strobes. All outputs pass through a configurable delay pipeline, so downstream pixel logic with ROM/RAM latency sees outputs already aligned with its own output. It replaces the fixed 640x480 sync block, and its defaults reproduce that mode.

## Interface
- HD, 640, active pixels per line
- HF, 16, horizontal front porch (pixels)
- HR, 96, horizontal sync width (pixels)
- HB, 48, horizontal back porch (pixels)
- VD, 480, active lines per frame
- VF, 10, vertical front porch (lines)
- VR, 2, vertical sync width (lines)
- VB, 33, vertical back porch (lines)
- HPOL, 0, sincH asserted level (0 = active-low)
- VPOL, 0, sincV asserted level (0 = active-low)
- XW, 11, pixelX width; must satisfy 2^XW ≥ HT
- YW, 10, pixelY width; must satisfy 2^YW ≥ VT
- PIPE, 0, extra output delay stages, 0..7
- clkP  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- ce  in  1  pixel tick; all state advances only on clkP edges with ce=1
- sincH  out  1  horizontal sync, polarity HPOL
- sincV  out  1  vertical sync, polarity VPOL
- video  out  1  1 inside the active HD×VD area
- pixelX  out  XW  column of the current output pixel
- pixelY  out  YW  line of the current output pixel
- inicioLinea  out  1  1 for one ce-tick when pixelX=0
- inicioFrame  out  1  1 for one ce-tick when pixelX=0 and pixelY=0

## Operation
- Derived constants: HT=HD+HF+HR+HB (default 800). VT=VD+VF+VR+VB (default 525).
- hCnt counts 0..HT-1 and wraps to 0. vCnt increments when hCnt wraps. vCnt counts 0..VT-1 and wraps to 0 together with hCnt at (HT-1, VT-1).
- Decode from (hCnt, vCnt):
  - active = hCnt<HD && vCnt<VD
  - hs = HD+HF ≤ hCnt ≤ HD+HF+HR-1
  - vs = VD+VF ≤ vCnt ≤ VD+VF+VR-1 (whole lines; sincV changes when hCnt=0)
- Output level: sincH = hs ? HPOL : ~HPOL. sincV uses vs and VPOL the same way.
- Stage 0 registers the decode and the counts on each ce edge. The counters advance on the same edge.
- Stage 0 then passes through PIPE further ce-gated register stages. All seven outputs are delayed identically.
- ce=0 holds every register, so outputs are stable between ticks.
- Reset: counters and every pipeline stage clear immediately. Outputs read video=0, pixelX=0, pixelY=0, both strobes 0, sincH=~HPOL, sincV=~VPOL.
- Reset released mid-frame restarts at (0,0). No partial-frame state is retained.
- Illegal parameters (any width ≤0 for HD/HR/VD/VR, widths too small for HT/VT, PIPE>7) are rejected by elaboration-time checks.

## Timing
- Latency from a counter value to its appearance on the outputs: 1+PIPE ce-ticks.
- With PIPE=0, the first ce edge after reset release outputs pixelX=0, pixelY=0, video=1, inicioLinea=1, inicioFrame=1.
- Line period: HT ce-ticks. Frame period: HT·VT ce-ticks.
- With defaults, sincH is low for pixelX 656..751, and sincV is low for pixelY 490..491.
- video=0 for pixelX≥640 or pixelY≥480.
- inicioFrame occurs once per frame. inicioLinea occurs VT times per frame.
- With ce tied high, the block runs at full clkP rate.

## Structure
- Package vga_pkg holds the default timing localparams (640x480@60 set) and the HT/VT derivation function, shared with the pixel generators.
- Sub-module vga_delay: a ce-gated, resettable shift register parameterised in width and depth (depth 0 is a wire). It is instantiated once on the concatenated {sincH, sincV, video, pixelX, pixelY, inicioLinea, inicioFrame} bus.
- All counter and decode logic stays in vga_timing_gen.

## Test plan
- Defaults, ce=1, reset 3 cycles then release:
  - first output is (0,0) with video=1 and both strobes high
  - next inicioFrame occurs exactly 420000 cycles later
- Defaults, check line 0:
  - sincH low exactly for pixelX 656..751 (96 ticks)
  - video high exactly for pixelX 0..639
- Defaults, full frame:
  - sincV low only for pixelY 490..491
  - pixelY wraps 524→0 at the same output tick that pixelX wraps 799→0
- ce pulsed 1-in-2:
  - outputs change only on ticks
  - line period is 1600 clkP cycles
  - outputs stay constant while ce=0
- PIPE=3, HPOL=1:
  - all outputs equal the PIPE=0 sequence delayed by 3 ticks
  - sincH high for pixelX 656..751
- Assert rst at pixel (300,200) between edges:
  - outputs go to reset values immediately, without waiting for a clock edge
  - after release the sequence restarts at (0,0)
